// File: rtl/mavg_pkg.sv
// rtl/mavg_pkg.sv - shared widths and sequencer phase constants for the moving averager
package mavg_pkg;

    // Phases within a channel slot at which the datapath acts
    localparam int PH_CAPTURE = 1;
    localparam int PH_UPDATE  = 2;
    localparam int PH_EMIT    = 3;

    // Running-sum width: a full window of full-scale samples plus one spare bit
    function automatic int sum_w(input int data_w, input int log2_win);
        return data_w + log2_win + 1;
    endfunction

    // Channel index width, never narrower than one bit
    function automatic int ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/mavg_history_ram.sv
// rtl/mavg_history_ram.sv - per-channel sample history, one read and one write port, self-clearing
module mavg_history_ram #(
    parameter int DATA_W     = 8,
    parameter int BANKS      = 2,
    parameter int DEPTH_LOG2 = 4,
    parameter int BANK_W     = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr_i,
    input  logic [BANK_W+DEPTH_LOG2-1:0] raddr_i,
    output logic [DATA_W-1:0]            rdata_o,
    input  logic                         we_i,
    input  logic [BANK_W+DEPTH_LOG2-1:0] waddr_i,
    input  logic [DATA_W-1:0]            wdata_i
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_LAST = '1;

    logic [DATA_W-1:0]     mem_q [BANKS*DEPTH];
    logic [DATA_W-1:0]     rdata_q;
    logic [DEPTH_LOG2-1:0] clr_ptr_q;
    logic                  clr_busy_q;

    // Clear pointer: restarts on reset or clr_i, then walks every row once
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clr_busy_q <= 1'b1;
            clr_ptr_q  <= '0;
        end else if (clr_i) begin
            clr_busy_q <= 1'b1;
            clr_ptr_q  <= '0;
        end else if (clr_busy_q) begin
            clr_ptr_q <= clr_ptr_q + 1'b1;
            if (clr_ptr_q == PTR_LAST) begin
                clr_busy_q <= 1'b0;
            end
        end
    end

    // Storage: zero one row in every bank per cycle, sequencer write takes priority; registered read
    always_ff @(posedge clk_i) begin
        if (clr_busy_q) begin
            for (int b = 0; b < BANKS; b++) begin
                mem_q[{BANK_W'(b), clr_ptr_q}] <= '0;
            end
        end
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/moving_average_mc.sv
// rtl/moving_average_mc.sv - multi-channel boxcar averager with ADC slot sequencer
module moving_average_mc
    import mavg_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int CHANNELS      = 2,
    parameter int LOG2_WIN      = 4,
    parameter int SLOT_CYCLES   = 4,
    parameter int GLITCH_CYCLES = 2,
    parameter int ROUND         = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       ENA,
    input  logic [CHANNELS*DATA_W-1:0] INPUT_ADC,
    output logic [CHANNELS-1:0]        CLK_ADC,
    output logic [DATA_W-1:0]          AVG_OUT,
    output logic [ch_w(CHANNELS)-1:0]  AVG_CH,
    output logic                       AVG_VALID,
    output logic [CHANNELS-1:0]        WINDOW_FULL,
    output logic [31:0]                SAMPLES_TAKEN
);
    localparam int SUM_W = sum_w(DATA_W, LOG2_WIN);
    localparam int CH_W  = ch_w(CHANNELS);
    localparam int PH_W  = $clog2(SLOT_CYCLES);
    localparam int GD_W  = (GLITCH_CYCLES > 0) ? $clog2(GLITCH_CYCLES + 1) : 1;
    localparam int WIN   = 1 << LOG2_WIN;
    localparam int AW    = CH_W + LOG2_WIN;

    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SLOT_CYCLES - 1);
    localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(SLOT_CYCLES / 2);
    localparam logic [PH_W-1:0]   PH_CAP    = PH_W'(PH_CAPTURE);
    localparam logic [PH_W-1:0]   PH_UPD    = PH_W'(PH_UPDATE);
    localparam logic [PH_W-1:0]   PH_EMT    = PH_W'(PH_EMIT);
    localparam logic [CH_W-1:0]   SLOT_LAST = CH_W'(CHANNELS - 1);
    localparam logic [GD_W-1:0]   GD_MAX    = GD_W'(GLITCH_CYCLES);
    localparam logic [LOG2_WIN:0] CNT_FULL  = (LOG2_WIN+1)'(WIN);
    localparam logic [SUM_W:0]    RND_ADD   = (SUM_W+1)'((ROUND != 0) ? WIN / 2 : 0);
    localparam logic [SUM_W:0]    OUT_MAX   = (SUM_W+1)'((1 << DATA_W) - 1);

    logic [GD_W-1:0]     guard_q, guard_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [CH_W-1:0]     slot_q, slot_d;
    logic [CHANNELS-1:0] clk_adc_q, clk_adc_d;
    logic [SUM_W-1:0]    sum_q  [CHANNELS];
    logic [LOG2_WIN-1:0] wptr_q [CHANNELS];
    logic [LOG2_WIN:0]   cnt_q  [CHANNELS];
    logic [DATA_W-1:0]   s_q, avg_q, avg_d;
    logic [CH_W-1:0]     avg_ch_q;
    logic                valid_q;
    logic [31:0]         samples_q;

    logic                run;
    logic [DATA_W-1:0]   adc [CHANNELS];
    logic [AW-1:0]       hist_addr;
    logic                hist_we;
    logic [DATA_W-1:0]   hist_rdata, oldest;
    logic [SUM_W:0]      rounded, shifted;

    assign run       = ENA && (guard_q == GD_MAX);
    assign hist_addr = {slot_q, wptr_q[slot_q]};
    assign hist_we   = run && (ph_q == PH_UPD);
    // Until a channel has a full window its oldest slot is logically zero, even mid-clear
    assign oldest    = (cnt_q[slot_q] == CNT_FULL) ? hist_rdata : '0;

    mavg_history_ram #(
        .DATA_W     (DATA_W),
        .BANKS      (CHANNELS),
        .DEPTH_LOG2 (LOG2_WIN),
        .BANK_W     (CH_W)
    ) u_hist (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clr_i   (!ENA),
        .raddr_i (hist_addr),
        .rdata_o (hist_rdata),
        .we_i    (hist_we),
        .waddr_i (hist_addr),
        .wdata_i (s_q)
    );

    // Split the packed ADC bus into per-channel samples
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            adc[c] = INPUT_ADC[c*DATA_W +: DATA_W];
        end
    end

    // Divide the current slot's sum by the window, optionally rounding, then saturate
    always_comb begin
        rounded = {1'b0, sum_q[slot_q]} + RND_ADD;
        shifted = rounded >> LOG2_WIN;
        avg_d   = (shifted > OUT_MAX) ? '1 : shifted[DATA_W-1:0];
    end

    // Next guard/phase/slot and the ADC clock pattern for the coming cycle
    always_comb begin
        guard_d   = guard_q;
        ph_d      = ph_q;
        slot_d    = slot_q;
        clk_adc_d = '0;
        if (!ENA) begin
            guard_d = '0;
            ph_d    = '0;
            slot_d  = '0;
        end else if (!run) begin
            guard_d = guard_q + 1'b1;
        end else if (ph_q == PH_LAST) begin
            ph_d   = '0;
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end else begin
            ph_d = ph_q + 1'b1;
        end
        if (ENA && (guard_d == GD_MAX) && (ph_d < PH_HALF)) begin
            clk_adc_d[slot_d] = 1'b1;
        end
    end

    // Sequencer state and registered ADC clocks
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            guard_q   <= '0;
            ph_q      <= '0;
            slot_q    <= '0;
            clk_adc_q <= '0;
        end else begin
            guard_q   <= guard_d;
            ph_q      <= ph_d;
            slot_q    <= slot_d;
            clk_adc_q <= clk_adc_d;
        end
    end

    // Datapath: capture, running-sum update, averaged output with one-cycle strobe
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s_q       <= '0;
            avg_q     <= '0;
            avg_ch_q  <= '0;
            valid_q   <= 1'b0;
            samples_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                sum_q[c]  <= '0;
                wptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            if (!ENA) begin
                samples_q <= '0;
                for (int c = 0; c < CHANNELS; c++) begin
                    sum_q[c]  <= '0;
                    wptr_q[c] <= '0;
                    cnt_q[c]  <= '0;
                end
            end else if (run) begin
                if (ph_q == PH_CAP) begin
                    s_q <= adc[slot_q];
                end
                if (ph_q == PH_UPD) begin
                    sum_q[slot_q]  <= sum_q[slot_q] + SUM_W'(s_q) - SUM_W'(oldest);
                    wptr_q[slot_q] <= wptr_q[slot_q] + 1'b1;
                    if (cnt_q[slot_q] != CNT_FULL) begin
                        cnt_q[slot_q] <= cnt_q[slot_q] + 1'b1;
                    end
                    samples_q <= samples_q + 32'd1;
                end
                if (ph_q == PH_EMT) begin
                    avg_q    <= avg_d;
                    avg_ch_q <= slot_q;
                    valid_q  <= 1'b1;
                end
            end
        end
    end

    // A channel's window is full once its sample count has saturated
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            WINDOW_FULL[c] = (cnt_q[c] == CNT_FULL);
        end
    end

    assign CLK_ADC       = clk_adc_q;
    assign AVG_OUT       = avg_q;
    assign AVG_CH        = avg_ch_q;
    assign AVG_VALID     = valid_q;
    assign SAMPLES_TAKEN = samples_q;

endmodule
